transposed_buffer_ctrl: RTL and testbench
=========================================

// Module: transposed_buffer_ctrl
// PURPOSE
//  Sequencer for the 4-wide x 9-deep transposed row buffer in the interpolation datapath.
//  Accepts input rows over a valid/ready handshake and drives the buffer write enable.
//  Once ROWS rows are resident, hands the columns one at a time to the filter stage.
//  Writes are blocked while columns drain, so buffer contents stay stable for the whole read.
// PARAMETERS
//  ROWS       9   rows per block (buffer depth)
//  COLS       4   columns per block (buffer width)
//  ROW_CNT_W  4   row counter width, >= clog2(ROWS+1)
//  COL_SEL_W  2   column select width, = clog2(COLS)
// PORTS
//  CLK           in   1          clock; all logic on rising edge
//  RST_SYNC      in   1          synchronous reset, active-high
//  FLUSH         in   1          drop the current block and restart a full fill
//  IN_VALID      in   1          an input row is presented to the buffer
//  IN_READY      out  1          controller accepts a row this cycle
//  BUF_WRITE_EN  out  1          buffer write/shift enable (= IN_VALID & IN_READY)
//  COL_VALID     out  1          column COL_SEL is valid on the buffer outputs
//  COL_READY     in   1          filter stage consumes the column
//  COL_SEL       out  COL_SEL_W  index of the column being presented (0..COLS-1)
//  COL_LAST      out  1          COL_VALID and COL_SEL == COLS-1
//  BLOCK_DONE    out  1          one-cycle pulse on the last column handshake
//  ROW_COUNT     out  ROW_CNT_W  rows written into the current block
// BEHAVIOUR
//  - FSM states: FILL, DRAIN. Reset state is FILL. Every register is synchronous.
//  - While RST_SYNC=1: state<=FILL, row_cnt<=0, col_cnt<=0, primed<=0.
//    On the reset cycle all outputs are 0 except IN_READY.
//    After reset: IN_READY=1, COL_VALID=0, BLOCK_DONE=0, COL_SEL=0, ROW_COUNT=0.
//  - FILL:
//    - IN_READY=1 and COL_VALID=0.
//    - Write = IN_VALID & IN_READY. BUF_WRITE_EN is combinational from IN_VALID.
//    - Each write increments row_cnt.
//    - When a write occurs with row_cnt == ROWS-1: row_cnt<=ROWS and state<=DRAIN.
//  - DRAIN:
//    - IN_READY=0, BUF_WRITE_EN=0, COL_VALID=1, COL_SEL=col_cnt.
//    - Entry is the cycle after the final write, so all ROWS rows are already registered.
//    - A handshake is COL_VALID & COL_READY and increments col_cnt.
//    - COL_READY=0 stalls the drain: COL_SEL holds and the buffer holds.
//    - Handshake with col_cnt == COLS-1: BLOCK_DONE=1 that cycle, col_cnt<=0, state<=FILL.
//      row_cnt<=0 in base mode; see CONFIGURATION for slide mode.
//  - Latency: first COL_VALID is 1 cycle after the ROWS-th write.
//    Minimum period is ROWS+COLS cycles per block (base mode).
//  - FLUSH:
//    - Overrides everything except RST_SYNC.
//    - Next cycle: state=FILL, row_cnt=0, col_cnt=0, primed=0.
//    - No BLOCK_DONE, and BUF_WRITE_EN is forced to 0 in the FLUSH cycle.
//  - Counters never wrap: row_cnt saturates at ROWS and col_cnt stays within 0..COLS-1.
//    IN_VALID is ignored in DRAIN and COL_READY is ignored in FILL.
//  - Reset or FLUSH mid-DRAIN abandons the remaining columns. The buffer is not cleared;
//    stale rows are shifted out by the next full fill.
// CONFIGURATION
//  - Macro TRANSPOSED_BUFFER_CTRL_SLIDE_EN selects sliding-window mode.
//  - Defined:
//    - After the first full block sets primed=1, the DRAIN->FILL exit loads row_cnt<=ROWS-1.
//    - Each later block therefore needs exactly one new row: a vertical slide of 1 row.
//    - Steady-state period is 1+COLS cycles.
//    - FLUSH or reset clears primed, so the next block needs ROWS rows again.
//  - Undefined: every block needs ROWS fresh rows, and the primed register is not built.
// TESTING
//  1. Reset, then IN_VALID=1 for 9 cycles with COL_READY=1:
//     -> BUF_WRITE_EN high for 9 cycles.
//     -> COL_VALID on cycles 10..13 with COL_SEL 0,1,2,3.
//     -> COL_LAST and BLOCK_DONE on cycle 13; IN_READY=1 again on cycle 14.
//  2. Full buffer, COL_READY=0 for 5 cycles, then 1:
//     -> COL_SEL holds 0 and COL_VALID stays 1 through the stall; BUF_WRITE_EN=0 throughout.
//     -> Columns 0..3 then complete.
//  3. IN_VALID toggling 1,0,1,0 during fill:
//     -> ROW_COUNT advances only on valid cycles.
//     -> DRAIN is entered only after the 9th accepted row.
//  4. FLUSH asserted at COL_SEL=2:
//     -> Next cycle: state FILL, ROW_COUNT=0, COL_VALID=0, no BLOCK_DONE.
//     -> 9 rows are needed for the next block.
//  5. RST_SYNC pulsed for 1 cycle during FILL with ROW_COUNT=5:
//     -> Next cycle: ROW_COUNT=0, IN_READY=1, all other outputs 0.
//  6. SLIDE_EN, two blocks back-to-back:
//     -> Block 2 enters DRAIN after 1 write (ROW_COUNT goes 8->9).
//     -> FLUSH then forces a 9-row fill.

Source files
------------

// File: rtl/transposed_buffer_ctrl.sv
// Fill/drain sequencer for the 4x9 transposed row buffer.
// Define TRANSPOSED_BUFFER_CTRL_SLIDE_EN for sliding-window (1-row slide) mode.
module transposed_buffer_ctrl #(
  parameter int ROWS      = 9,
  parameter int COLS      = 4,
  parameter int ROW_CNT_W = 4,
  parameter int COL_SEL_W = 2
) (
  input  logic                 CLK,
  input  logic                 RST_SYNC,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic                 BUF_WRITE_EN,
  output logic                 COL_VALID,
  input  logic                 COL_READY,
  output logic [COL_SEL_W-1:0] COL_SEL,
  output logic                 COL_LAST,
  output logic                 BLOCK_DONE,
  output logic [ROW_CNT_W-1:0] ROW_COUNT
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [ROW_CNT_W-1:0] ROW_FULL =
    ROW_CNT_W'(ROWS);
  localparam logic [ROW_CNT_W-1:0] ROW_LAST =
    ROW_CNT_W'(ROWS - 1);
  localparam logic [COL_SEL_W-1:0] COL_END =
    COL_SEL_W'(COLS - 1);

  state_t               state;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic [COL_SEL_W-1:0] col_cnt;
  logic                 live;
  logic                 wr;
  logic                 hs;
  logic                 at_end;

`ifdef TRANSPOSED_BUFFER_CTRL_SLIDE_EN
  logic primed;
`endif

  assign live   = ~RST_SYNC & ~FLUSH;
  assign at_end = (col_cnt == COL_END);

  // Reset and flush both suppress any write or column handshake.
  assign IN_READY     = (state == FILL);
  assign wr           = IN_VALID & IN_READY & live;
  assign BUF_WRITE_EN = wr;
  assign COL_VALID    = (state == DRAIN) & ~RST_SYNC;
  assign hs           = COL_VALID & COL_READY & ~FLUSH;
  assign COL_SEL      = RST_SYNC ? '0 : col_cnt;
  assign COL_LAST     = COL_VALID & at_end;
  assign BLOCK_DONE   = hs & at_end;
  assign ROW_COUNT    = RST_SYNC ? '0 : row_cnt;

  always_ff @(posedge CLK) begin
    if (RST_SYNC || FLUSH) begin
      state   <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
`ifdef TRANSPOSED_BUFFER_CTRL_SLIDE_EN
      primed  <= 1'b0;
`endif
    end else begin
      unique case (state)
        FILL: begin
          if (wr) begin
            if (row_cnt == ROW_LAST) begin
              row_cnt <= ROW_FULL;
              state   <= DRAIN;
`ifdef TRANSPOSED_BUFFER_CTRL_SLIDE_EN
              primed  <= 1'b1;
`endif
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            if (at_end) begin
              col_cnt <= '0;
              state   <= FILL;
`ifdef TRANSPOSED_BUFFER_CTRL_SLIDE_EN
              // Keep ROWS-1 rows resident: next block is a 1-row slide.
              row_cnt <= primed ? ROW_LAST : '0;
`else
              row_cnt <= '0;
`endif
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_transposed_buffer_ctrl.sv
// Directed bench for transposed_buffer_ctrl with a column scoreboard.
// Honours TRANSPOSED_BUFFER_CTRL_SLIDE_EN for the sliding-window scenario.
module tb_transposed_buffer_ctrl;

`ifdef TRANSPOSED_BUFFER_CTRL_SLIDE_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic       buf_we;
  logic       col_valid;
  logic       col_ready;
  logic [1:0] col_sel;
  logic       col_last;
  logic       block_done;
  logic [3:0] row_count;

  typedef struct {
    int sel;
    int last;
    int done;
  } col_t;

  col_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_rows = 0;
  bit   exp_primed = 1'b0;
  int   cnt;

  always #5 CLK = ~CLK;

  transposed_buffer_ctrl dut (
    .CLK          (CLK),
    .RST_SYNC     (rst),
    .FLUSH        (flush),
    .IN_VALID     (in_valid),
    .IN_READY     (in_ready),
    .BUF_WRITE_EN (buf_we),
    .COL_VALID    (col_valid),
    .COL_READY    (col_ready),
    .COL_SEL      (col_sel),
    .COL_LAST     (col_last),
    .BLOCK_DONE   (block_done),
    .ROW_COUNT    (row_count)
  );

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_block();
    for (int c = 0; c < 4; c++) begin
      col_t e;
      e.sel  = c;
      e.last = int'(c == 3);
      e.done = int'(c == 3);
      q.push_back(e);
    end
  endtask

  // One clock: score any column handshake, then advance.
  task automatic cyc();
    #1;
    if (col_valid && col_ready && !flush && !rst) begin
      chk("sb_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        col_t e;
        e = q.pop_front();
        chk("col_sel", int'(col_sel), e.sel);
        chk("col_last", int'(col_last), e.last);
        chk("block_done", int'(block_done), e.done);
      end
    end else begin
      chk("idle_done", int'(block_done), 0);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_full(output int n);
    n = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("fill_we", int'(buf_we), 1);
      chk("fill_rows", int'(row_count), exp_rows);
      chk("fill_cv", int'(col_valid), 0);
      exp_rows++;
      n++;
      if (exp_rows == 9) begin
        push_block();
        exp_primed = SLIDE;
      end
      cyc();
      if (exp_rows == 9) break;
    end
    in_valid = 1'b0;
    chk("fill_bound", exp_rows, 9);
  endtask

  task automatic drain();
    col_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      chk("drain_cv", int'(col_valid), 1);
      chk("drain_rdy", int'(in_ready), 0);
      chk("drain_rows", int'(row_count), 9);
      cyc();
    end
    chk("drain_bound", int'(q.size()), 0);
    q.delete();
    exp_rows = (SLIDE && exp_primed) ? 8 : 0;
    chk("exit_rows", int'(row_count), exp_rows);
    chk("exit_cv", int'(col_valid), 0);
    chk("exit_rdy", int'(in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    col_ready = 1'b0;
    @(posedge CLK);
    #1;
    in_valid = 1'b1;
    #1;
    chk("rst_we", int'(buf_we), 0);
    chk("rst_cv", int'(col_valid), 0);
    chk("rst_rows", int'(row_count), 0);
    chk("rst_sel", int'(col_sel), 0);
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rdy", int'(in_ready), 1);
    chk("post_cv", int'(col_valid), 0);
    chk("post_done", int'(block_done), 0);
    chk("post_sel", int'(col_sel), 0);
    chk("post_rows", int'(row_count), 0);

    // 1: straight fill then drain
    col_ready = 1'b1;
    fill_full(cnt);
    chk("t1_rows", cnt, 9);
    drain();

    // 2: stalled drain, writes blocked
    col_ready = 1'b0;
    fill_full(cnt);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_cv", int'(col_valid), 1);
      chk("stall_sel", int'(col_sel), 0);
      chk("stall_we", int'(buf_we), 0);
      chk("stall_last", int'(col_last), 0);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    // 3: start from a flushed block, gappy input
    flush = 1'b1;
    #1;
    chk("fl_fill_we", int'(buf_we), 0);
    cyc();
    flush = 1'b0;
    exp_rows = 0;
    exp_primed = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = (i % 2 == 0);
      #1;
      chk("tog_rows", int'(row_count), exp_rows);
      chk("tog_we", int'(buf_we), int'(in_valid));
      chk("tog_cv", int'(col_valid), 0);
      if (in_valid) exp_rows++;
      if (exp_rows == 9 && in_valid) begin
        push_block();
        exp_primed = SLIDE;
      end
      cyc();
    end
    in_valid = 1'b0;
    chk("tog_drain", int'(col_valid), 1);
    drain();

    // 4: flush at column 2
    fill_full(cnt);
    col_ready = 1'b1;
    cyc();
    cyc();
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("fl_sel", int'(col_sel), 2);
    chk("fl_we", int'(buf_we), 0);
    chk("fl_done", int'(block_done), 0);
    cyc();
    q.delete();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_rows = 0;
    exp_primed = 1'b0;
    #1;
    chk("fl_cv", int'(col_valid), 0);
    chk("fl_rows", int'(row_count), 0);
    chk("fl_rdy", int'(in_ready), 1);
    chk("fl_done2", int'(block_done), 0);
    fill_full(cnt);
    chk("fl_refill", cnt, 9);
    drain();

    // 5: reset mid-fill
    if (exp_rows != 0) begin
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      exp_rows = 0;
      exp_primed = 1'b0;
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp_rows++;
    end
    chk("r5_rows", int'(row_count), 5);
    rst = 1'b1;
    #1;
    chk("r5_we", int'(buf_we), 0);
    chk("r5_rows0", int'(row_count), 0);
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_rows = 0;
    exp_primed = 1'b0;
    #1;
    chk("r5_after", int'(row_count), 0);
    chk("r5_rdy", int'(in_ready), 1);
    chk("r5_cv", int'(col_valid), 0);
    chk("r5_we2", int'(buf_we), 0);
    chk("r5_sel", int'(col_sel), 0);
    chk("r5_last", int'(col_last), 0);

    // 6: back-to-back blocks, then flush
    fill_full(cnt);
    chk("b1_rows", cnt, 9);
    drain();
    fill_full(cnt);
    chk("b2_rows", cnt, SLIDE ? 1 : 9);
    drain();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    exp_rows = 0;
    exp_primed = 1'b0;
    chk("b3_start", int'(row_count), 0);
    fill_full(cnt);
    chk("b3_rows", cnt, 9);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
